serial_adder_ctrl: RTL and testbench

Bit-serial adder sequencer that drives the team's 3-input combinational full-adder cell one bit per clock. It accepts two WIDTH-bit operands and a carry-in on a start strobe. Each cycle it presents {a_bit, b_bit, carry} to the full adder, registers the returned carry, and shifts the returned sum bit into a result register. It trades WIDTH cycles of latency for a single full-adder instance.

---
 rtl/serial_adder_ctrl.sv | 88 ++++++++
 tb/tb_serial_adder_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: feeds one operand bit pair plus the running carry
// per clock to an external full-adder cell and assembles the result LSB first.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [2:0]       fa_i,
    input  logic             fa_sum,
    input  logic             fa_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             c;
    logic             cout_r;
    logic [CW-1:0]    cnt;

    // Sum bits enter at the MSB so the LSB-first stream ends up right-aligned.
    generate
        if (WIDTH == 1) begin : g_one
            assign sum_next = fa_sum;
        end else begin : g_wide
            assign sum_next = {fa_sum, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            c      <= 1'b0;
            sum_sh <= '0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= sum_next;
                    c      <= fa_carry;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state  <= DONE;
                        cout_r <= fa_carry;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign fa_i = (state == RUN) ? {a_sh[0], b_sh[0], c} : 3'b000;
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign sum  = sum_sh;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1, checked
// against an arithmetic model of the add and its handshake timing.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       start8, cin8, fs8, fc8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic [2:0] fa8;

    logic       start1, cin1, fs1, fc1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    logic [2:0] fa1;

    int total = 0;
    int passes = 0;
    logic mon_en = 1'b0;

    // Behavioural model of the team's full-adder cell.
    assign fs8 = ^fa8;
    assign fc8 = (fa8[2] & fa8[1]) | (fa8[2] & fa8[0]) | (fa8[1] & fa8[0]);
    assign fs1 = ^fa1;
    assign fc1 = (fa1[2] & fa1[1]) | (fa1[2] & fa1[0]) | (fa1[1] & fa1[0]);

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .fa_i(fa8), .fa_sum(fs8), .fa_carry(fc8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .fa_i(fa1), .fa_sum(fs1), .fa_carry(fc1), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bit j of the add sees operand bits j and the carry out of the lower j bits.
    function automatic logic [2:0] expFa(input int a, input int b, input int ci, input int r, input int w);
        int j, carry;
        if (r < 2) return 3'b000;
        j = w + 1 - r;
        carry = ((a & ((1 << j) - 1)) + (b & ((1 << j) - 1)) + ci) >> j;
        return {1'((a >> j) & 1), 1'((b >> j) & 1), 1'(carry & 1)};
    endfunction

    // Reference: r counts edges left until IDLE; result appears as r reaches 1.
    int r8, r1;
    int ma8, mb8, mc8, ma1, mb1, mc1;
    logic [8:0] mout8;
    logic [1:0] mout1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r8 = 0; mout8 = '0;
            r1 = 0; mout1 = '0;
        end else begin
            if (r8 == 0) begin
                if (start8) begin r8 = 9; ma8 = a8; mb8 = b8; mc8 = cin8; end
            end else begin
                r8--;
                if (r8 == 1) mout8 = 9'(ma8 + mb8 + mc8);
            end
            if (r1 == 0) begin
                if (start1) begin r1 = 2; ma1 = a1; mb1 = b1; mc1 = cin1; end
            end else begin
                r1--;
                if (r1 == 1) mout1 = 2'(ma1 + mb1 + mc1);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("busy8", busy8, r8 != 0);
            checkOutput("done8", done8, r8 == 1);
            checkOutput("fa8", fa8, expFa(ma8, mb8, mc8, r8, 8));
            if (r8 <= 1) checkOutput("res8", {cout8, sum8}, mout8);
            checkOutput("busy1", busy1, r1 != 0);
            checkOutput("done1", done1, r1 == 1);
            checkOutput("fa1", fa1, expFa(ma1, mb1, mc1, r1, 1));
            if (r1 <= 1) checkOutput("res1", {cout1, sum1}, mout1);
        end
    end

    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        logic [8:0] e;
        int lat;
        e = 9'(ta + tb + tc);
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput("latency8", lat, 8);
        checkOutput("sum8", {cout8, sum8}, e);
        @(posedge clk); #1;
        checkOutput("idle8", busy8, 1'b0);
    endtask

    task automatic applyStimulus1(input logic [2:0] v);
        a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        checkOutput("w1_early", done1, 1'b0);
        @(posedge clk); #1;
        checkOutput("w1_done", done1, 1'b1);
        checkOutput("w1_sum", {cout1, sum1}, 2'(v[2] + v[1] + v[0]));
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy8, 1'b0);
        checkOutput("rst_res", {cout8, sum8, fa8, done8}, '0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(8'h5A, 8'h3C, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        applyStimulus(8'h01, 8'h80, 1'b1);

        // Start held high with operands churning every cycle.
        start8 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
        end
        // Sparse random start pulses, including during RUN/DONE.
        for (int i = 0; i < 300; i++) begin
            start8 = ($urandom_range(0, 3) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        // Abort mid-RUN: outputs clear without waiting for a clock edge.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy8, 1'b0);
        checkOutput("abort_done", done8, 1'b0);
        checkOutput("abort_out", {cout8, sum8, fa8}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(8'h10, 8'h20, 1'b0);

        for (int v = 0; v < 8; v++) applyStimulus1(3'(v));

        for (int i = 0; i < 10; i++)
            applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
